// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit for the execute stage.
//
// Takes one M-extension operation through a valid/ready handshake, resolves
// BITS_PER_CYCLE product or quotient bits per cycle, and returns a tagged
// result with full RISC-V semantics (signed/unsigned high products,
// round-toward-zero division, divide-by-zero and signed-overflow results).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               kills any in-flight operation, result is discarded
//   in_valid/in_ready   request handshake; in_ready only in IDLE
//   op                  funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   operand1/operand2   rs1 / rs2 values
//   in_tag              destination tag carried to out_tag
//   out_valid/out_ready result handshake; result/out_tag held while stalled
//   result, out_tag     result value and its tag
//   busy                pipeline stall request (state != IDLE)

module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  operand1,
    input  logic [XLEN-1:0]  operand2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [XLEN-1:0]   a_q, b_q;       // raw operands, replaced by magnitudes in PREP
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;
    logic              sign_a_q, sign_b_q;
    logic              special_q;
    logic [2*XLEN-1:0] acc_q;          // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    // ---------------------------------------------------------------- decode
    logic is_div, is_rem, signed_a, signed_b;

    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign signed_a = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign signed_b = op_q inside {OP_MULH, OP_DIV, OP_REM};

    // ---------------------------------------------------------------- PREP
    logic            sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign sign_a   = signed_a & a_q[XLEN-1];
    assign sign_b   = signed_b & b_q[XLEN-1];
    assign mag_a    = sign_a ? -a_q : a_q;
    assign mag_b    = sign_b ? -b_q : b_q;
    assign div_zero = (b_q == '0);
    assign div_ovf  = (op_q inside {OP_DIV, OP_REM})
                      && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign special  = is_div && (div_zero || div_ovf);
    // Divide-by-zero has priority: it also covers REM of the overflow dividend by 0.
    assign special_res = div_zero ? (is_rem ? a_q : '1)
                                  : (is_rem ? '0  : a_q);

    // ---------------------------------------------------------------- CALC
    // Multiply: add multiplicand * (low B multiplier bits) into the upper half,
    // then shift the whole accumulator right by B.
    logic [XLEN+B-1:0] mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum  = {{B{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                    + ({{B{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[B-1:0]});
    assign mul_next = {mul_sum, acc_q[XLEN-1:B]};

    // Divide: B restoring steps per cycle. The partial remainder is one bit
    // wider than the divisor so the trial subtraction cannot overflow.
    always_comb begin : div_step
        logic [2*XLEN-1:0] t;
        logic [XLEN:0]     r;
        // NOTE: t and r are fully assigned before being read on every pass,
        // so this stays combinational and no latch is inferred.
        t = acc_q;
        for (int i = 0; i < B; i++) begin
            r = t[2*XLEN-1:XLEN-1];
            if (r >= {1'b0, b_q}) begin
                r = r - {1'b0, b_q};
                t = {r[XLEN-1:0], t[XLEN-2:0], 1'b1};
            end else begin
                t = {r[XLEN-1:0], t[XLEN-2:0], 1'b0};
            end
        end
        div_next = t;
    end

    // ---------------------------------------------------------------- FIX
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                    fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:           fix_res = quo;
            default:                   fix_res = rem;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_PREP;
            end
            // Special cases skip CALC; FIX then passes the preset result through.
            S_PREP: state_d = special ? S_FIX : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    assign accept = in_ready & in_valid & ~flush;

    // ---------------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: accumulator and operand registers are cleared too, so no X
            // can leak into result through unused accumulator bits.
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q  <= op_t'(op);
                    a_q   <= operand1;
                    b_q   <= operand2;
                    tag_q <= in_tag;
                end
                S_PREP: begin
                    sign_a_q  <= sign_a;
                    sign_b_q  <= sign_b;
                    a_q       <= mag_a;
                    b_q       <= mag_b;
                    acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_q     <= CNT_W'(N);
                    special_q <= special;
                    if (special) result_q <= special_res;
                end
                S_CALC: begin
                    acc_q <= is_div ? div_next : mul_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: if (!special_q) result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign result  = result_q;
    assign out_tag = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Two instances (BITS_PER_CYCLE = 1 and 4)
// share the stimulus; 'sel' routes the handshake to one of them at a time.
// Expected results come from a 64-bit arithmetic reference of the RV32M rules.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, sel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  in_tag;

    logic        ir1, ov1, bz1, ir4, ov4, bz4;
    logic [31:0] r1, r4;
    logic [4:0]  t1, t4;

    logic        in_ready_o, out_valid_o, busy_o;
    logic [31:0] result_o;
    logic [4:0]  out_tag_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_bpc1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & ~sel), .in_ready(ir1),
        .op(op), .operand1(a), .operand2(b), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(out_ready & ~sel),
        .result(r1), .out_tag(t1), .busy(bz1)
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_bpc4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & sel), .in_ready(ir4),
        .op(op), .operand1(a), .operand2(b), .in_tag(in_tag),
        .out_valid(ov4), .out_ready(out_ready & sel),
        .result(r4), .out_tag(t4), .busy(bz4)
    );

    assign in_ready_o  = sel ? ir4 : ir1;
    assign out_valid_o = sel ? ov4 : ov1;
    assign busy_o      = sel ? bz4 : bz1;
    assign result_o    = sel ? r4  : r1;
    assign out_tag_o   = sel ? t4  : t1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ reference
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: begin p = sx * sy;            return p[31:0];  end
            3'd1: begin p = sx * sy;            return p[63:32]; end
            3'd2: begin p = sx * longint'(uy);  return p[63:32]; end
            3'd3: begin p = ux * uy;            return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int bpc);
        bit special;
        special = (o >= 3'd4) && ((y == 0) ||
                  ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        return special ? 2 : (32 / bpc) + 2;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------ drivers
    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        int guard = 0;
        op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
        while (!in_ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready_o) check("accept_timeout", 64'(in_ready_o), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom; in_tag = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_o) check("done_timeout", 64'(out_valid_o), 64'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t,
                          output logic [31:0] res, output logic [4:0] tg, output int lat);
        start_op(o, x, y, t);
        wait_valid(lat);
        res = result_o;
        tg  = out_tag_o;
        retire();
    endtask

    task automatic directed(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  tg, t;
        int          lat;
        t = 5'($urandom_range(1, 31));
        run_op(o, x, y, t, res, tg, lat);
        check({name, "_result"}, 64'(res), 64'(exp));
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_tag"}, 64'(tg), 64'(t));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ sequence
    initial begin
        logic [31:0] res, x, y;
        logic [4:0]  tg, t;
        logic [2:0]  o;
        int          lat;
        bit          seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        op = '0; a = '0; b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_result",    64'(result_o),    64'd0);
        check("reset_out_tag",   64'(out_tag_o),   64'd0);
        check("reset_busy",      64'(busy_o),      64'd0);
        check("reset_in_ready",  64'(in_ready_o),  64'd1);

        // Main function, BITS_PER_CYCLE = 1
        directed("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        directed("mulh",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        directed("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        directed("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        directed("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        directed("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        directed("divu",     3'd5, 32'd100,        32'd7,         32'd14,        34);
        directed("remu",     3'd7, 32'd100,        32'd7,         32'd2,         34);

        // Special cases
        directed("divu_by0", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        directed("rem_by0",  3'd6, 32'd5,          32'd0,         32'd5,         2);
        directed("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        directed("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);

        // Backpressure: DONE held 5 cycles, a request pulse in the middle is ignored
        start_op(3'd5, 32'd1000, 32'd3, 5'd9);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                op = 3'd0; a = 32'd2; b = 32'd3; in_tag = 5'd30; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid_o), 64'd1);
            check("bp_result",    64'(result_o),    64'd333);
            check("bp_out_tag",   64'(out_tag_o),   64'd9);
            check("bp_in_ready",  64'(in_ready_o),  64'd0);
        end
        in_valid = 1'b0;
        retire();
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid_o || busy_o) seen = 1'b1;
        end
        check("bp_pulse_ignored", 64'(seen), 64'd0);

        // Flush mid-CALC
        start_op(3'd4, 32'd12345, 32'd7, 5'd3);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy",      64'(busy_o),      64'd0);
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_in_ready",  64'(in_ready_o),  64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush beats a request in IDLE
        op = 3'd0; a = 32'd4; b = 32'd5; in_tag = 5'd1;
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_vs_accept_busy", 64'(busy_o), 64'd0);

        // Reset mid-CALC (result still holds 333 from the backpressure op)
        start_op(3'd0, 32'd3, 32'd5, 5'd17);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_result",    64'(result_o),    64'd0);
        check("rst_out_tag",   64'(out_tag_o),   64'd0);
        check("rst_busy",      64'(busy_o),      64'd0);

        // BITS_PER_CYCLE = 4
        sel = 1'b1;
        @(posedge clk); #1;
        directed("b4_div", 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 10);
        directed("b4_mul", 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
        directed("b4_rem_by0", 3'd6, 32'd5,     32'd0,         32'd5,         2);

        // Random sweep against the reference at both settings
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(posedge clk); #1;
            for (int i = 0; i < (s == 0 ? 800 : 2000); i++) begin
                o = 3'($urandom_range(0, 7));
                x = rand_operand();
                y = rand_operand();
                t = 5'($urandom);
                run_op(o, x, y, t, res, tg, lat);
                check("rand_result",  64'(res), 64'(ref_result(o, x, y)));
                check("rand_tag",     64'(tg),  64'(t));
                check("rand_latency", 64'(lat), 64'(ref_latency(o, x, y, s == 0 ? 1 : 4)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
